vape_region_cfg_ctrl: RTL and testbench
=======================================

Name: vape_region_cfg_ctrl

Overview:
- Configuration and sequencing controller for the VAPE output-protection monitor.
- Owns the four region-bound registers (ER_min, ER_max, OR_min, OR_max), which the CPU writes through a memory-mapped window, and drives them to the monitor.
- Locks the bounds while the executable region (ER) runs, tracks each run from entry to legal exit, and counts completed runs that the monitor still reports as valid (exec_in high).

Parameters:
- CFG_BASE, 16'h0140, word-aligned base of the 4-word config window (+0 ER_min, +2 ER_max, +4 OR_min, +6 OR_max).
- RESET_HANDLER, 16'h0000, PC value that forces a soft return to IDLE.
- RUN_CNT_W, 8, width of the completed-run counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pc  in  16  current program counter.
- data_addr  in  16  CPU data address.
- data_wr  in  1  CPU data write strobe.
- data_wdata  in  16  CPU write data.
- dma_addr  in  16  DMA address.
- dma_en  in  1  DMA access strobe.
- exec_in  in  1  exec flag from the output-protection monitor.
- ER_min, ER_max, OR_min, OR_max  out  16 each  registered bounds driven to the monitor.
- cfg_valid  out  1  combinational: ER_min <= ER_max and OR_min < OR_max.
- state_o  out  3  current FSM state encoding.
- run_done  out  1  one-cycle pulse on entry to DONE.
- run_count  out  RUN_CNT_W  saturating count of DONE entries.

Behaviour:
- Reset (rst=1 at a clk edge): all four bounds 0, state IDLE, run_done 0, run_count 0.
- cfg_hit: data_wr high and data_addr within CFG_BASE..CFG_BASE+7. Register select uses data_addr[2:1]; bit 0 is ignored.
- A cfg_hit write updates its register at the clk edge only in IDLE, ARMED, DONE or FAIL. In RUN the write is discarded.
- States: IDLE=0, ARMED=1, RUN=2, DONE=3, FAIL=4.
- Priority in every state (highest first): rst, then pc==RESET_HANDLER, then the state rules below.
  - pc==RESET_HANDLER forces IDLE. Registers and run_count are kept.
- IDLE -> ARMED when cfg_valid is true and there is no cfg_hit that cycle.
- ARMED:
  - pc==ER_min -> RUN. This wins over a same-cycle cfg_hit; that write is discarded.
  - Otherwise, cfg_hit -> IDLE, with the register updated.
- RUN (rules in priority order):
  - cfg_hit, or exec_in==0 -> FAIL.
  - pc outside [ER_min, ER_max] -> DONE if the previous-cycle pc == ER_max (legal exit), else FAIL.
  - Otherwise stay in RUN.
  - A one-register prev_pc tracks the previous-cycle pc and is updated every cycle.
- DONE:
  - Entry: run_done=1 for one cycle, and run_count increments, saturating at all-ones.
  - pc==ER_min with cfg_valid -> RUN (re-execution).
  - cfg_hit -> IDLE, with the register updated.
  - Otherwise hold.
- FAIL (sticky):
  - cfg_hit -> IDLE, with the register updated.
  - pc==ER_min with cfg_valid -> RUN.
  - No run_done pulse and no count increment.
- Entry check: cfg_valid is evaluated on the pre-write register values in the same cycle.
- Boundary cases:
  - ER_min==ER_max is legal: a single-instruction region; exit from it is legal.
  - A pc-wraparound exit is handled like any other exit, by the same previous-pc rule.
- All outputs except cfg_valid are registered. Bounds are visible at the outputs one cycle after the write.

Optional Feature:
- Macro: VAPE_CFG_DMA_LOCK_EN.
- Defined:
  - dma_en high with dma_addr inside the config window forces FAIL from ARMED, RUN or DONE.
  - In IDLE and FAIL the access is ignored.
  - DMA never modifies the bound registers.
- Undefined: dma_addr and dma_en are ignored entirely; the ports remain present.

Decomposition:
- Package vape_cfg_pkg holds:
  - state encodings IDLE..FAIL;
  - register offsets OFF_ER_MIN=0, OFF_ER_MAX=2, OFF_OR_MIN=4, OFF_OR_MAX=6;
  - window size 8.
- Sub-module vape_cfg_regfile: the 4x16 bound registers, window decode and write enable (with a lock input). It outputs the bounds and cfg_hit.
- The FSM, prev_pc and counter stay in the top module.

Test Plan:
- Configure bounds 0xE000/0xE0FE/0x0200/0x0210, then sweep pc 0xE000..0xE0FE followed by 0x4400 with exec_in=1 -> states IDLE->ARMED->RUN->DONE, run_done pulses once, run_count=1.
- During RUN, write 0x1234 to CFG_BASE+2 -> FAIL next cycle and ER_max stays 0xE0FE.
- During RUN, jump pc from 0xE010 to 0x4400 -> FAIL, run_count unchanged.
- Write OR_min=0x0300 with OR_max=0x0210 -> cfg_valid=0, state stays IDLE, and pc=0xE000 does not enter RUN.
- In ARMED, present pc=ER_min and a cfg_hit write in the same cycle -> RUN is entered and the register is unchanged.
- With VAPE_CFG_DMA_LOCK_EN defined, in DONE, dma_en=1 with dma_addr=CFG_BASE+4 -> FAIL and OR_min unchanged. Without the macro -> state stays DONE.

Source files
------------

// File: rtl/vape_cfg_pkg.sv
// vape_cfg_pkg: state encodings, config window layout and window decode helper for the VAPE config controller
package vape_cfg_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t ARMED = 3'd1;
  localparam state_t RUN   = 3'd2;
  localparam state_t DONE  = 3'd3;
  localparam state_t FAIL  = 3'd4;
  localparam logic [2:0] OFF_ER_MIN = 3'd0;
  localparam logic [2:0] OFF_ER_MAX = 3'd2;
  localparam logic [2:0] OFF_OR_MIN = 3'd4;
  localparam logic [2:0] OFF_OR_MAX = 3'd6;
  localparam logic [15:0] WIN_SIZE = 16'd8;
  function automatic logic in_win(input logic [15:0] a, input logic [15:0] base);
    return a >= base && a <= base + WIN_SIZE - 16'd1;
  endfunction
endpackage

// File: rtl/vape_region_cfg_ctrl_if.sv
// vape_region_cfg_ctrl_if: CPU/DMA/monitor side signals of the VAPE config controller
interface vape_region_cfg_ctrl_if #(parameter int RUN_CNT_W = 8);
  logic [15:0] pc, data_addr, data_wdata, dma_addr;
  logic data_wr, dma_en, exec_in;
  logic [15:0] ER_min, ER_max, OR_min, OR_max;
  logic cfg_valid, run_done;
  logic [2:0] state_o;
  logic [RUN_CNT_W-1:0] run_count;
  modport master(output pc, data_addr, data_wr, data_wdata, dma_addr, dma_en, exec_in,
                 input ER_min, ER_max, OR_min, OR_max, cfg_valid, state_o, run_done, run_count);
  modport slave(input pc, data_addr, data_wr, data_wdata, dma_addr, dma_en, exec_in,
                output ER_min, ER_max, OR_min, OR_max, cfg_valid, state_o, run_done, run_count);
endinterface

// File: rtl/vape_cfg_regfile.sv
// vape_cfg_regfile: the four region-bound registers behind the memory-mapped config window
module vape_cfg_regfile
  import vape_cfg_pkg::*;
#(
  parameter logic [15:0] CFG_BASE = 16'h0140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        wr,
  input  logic        lock,
  output logic [15:0] er_min,
  output logic [15:0] er_max,
  output logic [15:0] or_min,
  output logic [15:0] or_max,
  output logic        cfg_hit
);
  logic [2:0] sel;
  logic we;
  assign cfg_hit = wr && in_win(addr, CFG_BASE);
  assign sel = {addr[2:1], 1'b0};
  assign we = cfg_hit && !lock;
  // bound registers: a window write lands unless the controller has locked the bounds
  always_ff @(posedge clk) begin
    if (rst) begin
      er_min <= '0;
      er_max <= '0;
      or_min <= '0;
      or_max <= '0;
    end else if (we) begin
      if (sel == OFF_ER_MIN) er_min <= wdata;
      if (sel == OFF_ER_MAX) er_max <= wdata;
      if (sel == OFF_OR_MIN) or_min <= wdata;
      if (sel == OFF_OR_MAX) or_max <= wdata;
    end
  end
endmodule

// File: rtl/vape_region_cfg_ctrl.sv
// vape_region_cfg_ctrl: VAPE region config/sequencing controller; optional DMA lock via VAPE_CFG_DMA_LOCK_EN
module vape_region_cfg_ctrl
  import vape_cfg_pkg::*;
#(
  parameter logic [15:0] CFG_BASE      = 16'h0140,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          RUN_CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  vape_region_cfg_ctrl_if.slave bus
);
  state_t state, nxt;
  logic [15:0] prev_pc;
  logic cfg_hit, lock, dma_hit, pc_min, in_er, done_entry;
  assign pc_min = bus.pc == bus.ER_min;
  assign in_er = bus.pc >= bus.ER_min && bus.pc <= bus.ER_max;
  assign lock = state == RUN || (state == ARMED && pc_min);
  assign bus.cfg_valid = bus.ER_min <= bus.ER_max && bus.OR_min < bus.OR_max;
  assign bus.state_o = state;
  assign done_entry = nxt == DONE && state != DONE;
`ifdef VAPE_CFG_DMA_LOCK_EN
  assign dma_hit = bus.dma_en && in_win(bus.dma_addr, CFG_BASE) &&
                   (state == ARMED || state == RUN || state == DONE);
`else
  logic unused_dma;
  assign unused_dma = ^{bus.dma_addr, bus.dma_en};
  assign dma_hit = 1'b0;
`endif
  vape_cfg_regfile #(.CFG_BASE(CFG_BASE)) u_regs (
    .clk(clk), .rst(rst), .addr(bus.data_addr), .wdata(bus.data_wdata), .wr(bus.data_wr),
    .lock(lock), .er_min(bus.ER_min), .er_max(bus.ER_max), .or_min(bus.OR_min),
    .or_max(bus.OR_max), .cfg_hit(cfg_hit)
  );
  // next state: reset handler first, then DMA lock, then per-state rules; unknown codes recover to IDLE
  always_comb begin
    nxt = IDLE;
    if (bus.pc == RESET_HANDLER) nxt = IDLE;
    else if (dma_hit) nxt = FAIL;
    else if (state == IDLE) nxt = bus.cfg_valid && !cfg_hit ? ARMED : IDLE;
    else if (state == ARMED) nxt = pc_min ? RUN : cfg_hit ? IDLE : ARMED;
    else if (state == RUN) nxt = cfg_hit || !bus.exec_in ? FAIL : in_er ? RUN : prev_pc == bus.ER_max ? DONE : FAIL;
    else if (state == DONE) nxt = pc_min && bus.cfg_valid ? RUN : cfg_hit ? IDLE : DONE;
    else if (state == FAIL) nxt = cfg_hit ? IDLE : pc_min && bus.cfg_valid ? RUN : FAIL;
  end
  // state, previous pc and completed-run bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev_pc <= '0;
      bus.run_done <= 1'b0;
      bus.run_count <= '0;
    end else begin
      state <= nxt;
      prev_pc <= bus.pc;
      bus.run_done <= done_entry;
      if (done_entry && bus.run_count != {RUN_CNT_W{1'b1}}) bus.run_count <= bus.run_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_vape_region_cfg_ctrl.sv
// tb_vape_region_cfg_ctrl: table-driven scoreboard bench for vape_region_cfg_ctrl
module tb_vape_region_cfg_ctrl;
  localparam logic [15:0] B = 16'h0140;
  typedef struct {
    logic [15:0] pc, addr, wdata, dma_addr;
    logic wr, exec_in, dma_en;
    logic [2:0] st;
    logic rd, cv;
    logic [7:0] rc;
    logic [15:0] ermax, ormin;
  } vec_t;
  typedef struct {
    logic [2:0] st;
    logic rd, cv;
    logic [7:0] rc;
    logic [15:0] ermax, ormin;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];
  exp_t sb[$];
  vape_region_cfg_ctrl_if #(.RUN_CNT_W(8)) bus();
  vape_region_cfg_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic void add(input logic [15:0] pc, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic ex, input logic de,
                              input logic [15:0] da, input logic [2:0] st, input logic rd,
                              input logic [7:0] rc, input logic cv, input logic [15:0] ermax,
                              input logic [15:0] ormin);
    vec_t v;
    v.pc = pc; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exec_in = ex; v.dma_en = de;
    v.dma_addr = da; v.st = st; v.rd = rd; v.rc = rc; v.cv = cv; v.ermax = ermax; v.ormin = ormin;
    tbl.push_back(v);
  endfunction
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    bus.pc = 16'h4400; bus.data_wr = 0; bus.data_addr = 0; bus.data_wdata = 0;
    bus.exec_in = 1; bus.dma_en = 0; bus.dma_addr = 0;
    add(16'h4400, 1, B+0, 16'hE000, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    add(16'h4400, 1, B+2, 16'hE0FE, 1, 0, 0, 0, 0, 0, 0, 16'hE0FE, 16'h0000);
    add(16'h4400, 1, B+4, 16'h0200, 1, 0, 0, 0, 0, 0, 0, 16'hE0FE, 16'h0200);
    add(16'h4400, 1, B+6, 16'h0210, 1, 0, 0, 0, 0, 0, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 16'hE0FE, 16'h0200);
    for (int p = 16'hE000; p <= 16'hE0FE; p += 2)
      add(16'(p), 0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 3, 1, 1, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 3, 0, 1, 1, 16'hE0FE, 16'h0200);
    add(16'hE000, 0, 0, 0, 1, 0, 0, 2, 0, 1, 1, 16'hE0FE, 16'h0200);
    add(16'hE002, 1, B+2, 16'h1234, 1, 0, 0, 4, 0, 1, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 4, 0, 1, 1, 16'hE0FE, 16'h0200);
    add(16'hE000, 0, 0, 0, 1, 0, 0, 2, 0, 1, 1, 16'hE0FE, 16'h0200);
    add(16'hE010, 0, 0, 0, 1, 0, 0, 2, 0, 1, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 4, 0, 1, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 1, B+2, 16'hE000, 1, 0, 0, 0, 0, 1, 1, 16'hE000, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 16'hE000, 16'h0200);
    add(16'hE000, 1, B+2, 16'hE0FE, 1, 0, 0, 2, 0, 1, 1, 16'hE000, 16'h0200);
    add(16'hE002, 0, 0, 0, 1, 0, 0, 3, 1, 2, 1, 16'hE000, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 3, 0, 2, 1, 16'hE000, 16'h0200);
`ifdef VAPE_CFG_DMA_LOCK_EN
    add(16'h4400, 0, 0, 0, 1, 1, B+4, 4, 0, 2, 1, 16'hE000, 16'h0200);
`else
    add(16'h4400, 0, 0, 0, 1, 1, B+4, 3, 0, 2, 1, 16'hE000, 16'h0200);
`endif
    add(16'h4400, 1, B+2, 16'hE0FE, 1, 0, 0, 0, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 1, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'hE000, 0, 0, 0, 1, 0, 0, 2, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'hE002, 0, 0, 0, 0, 0, 0, 4, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 1, B+4, 16'h0300, 1, 0, 0, 0, 0, 2, 0, 16'hE0FE, 16'h0300);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 16'hE0FE, 16'h0300);
    add(16'hE000, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 16'hE0FE, 16'h0300);
    add(16'h4400, 1, B+4, 16'h0200, 1, 0, 0, 0, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 1, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 0, 0, 0, 1, 0, 0, 1, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'hE000, 0, 0, 0, 1, 0, 0, 2, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 16'hE0FE, 16'h0200);
    add(16'h4400, 1, B+3, 16'hE100, 1, 0, 0, 0, 0, 2, 1, 16'hE100, 16'h0200);
    add(16'h4400, 1, B+8, 16'hFFFF, 1, 0, 0, 1, 0, 2, 1, 16'hE100, 16'h0200);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", -1, 32'(bus.state_o), 32'd0);
    chk("rst_er_min", -1, 32'(bus.ER_min), 32'd0);
    chk("rst_or_max", -1, 32'(bus.OR_max), 32'd0);
    chk("rst_run_done", -1, 32'(bus.run_done), 32'd0);
    chk("rst_run_count", -1, 32'(bus.run_count), 32'd0);
    chk("rst_cfg_valid", -1, 32'(bus.cfg_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      bus.pc = tbl[i].pc; bus.data_wr = tbl[i].wr; bus.data_addr = tbl[i].addr;
      bus.data_wdata = tbl[i].wdata; bus.exec_in = tbl[i].exec_in;
      bus.dma_en = tbl[i].dma_en; bus.dma_addr = tbl[i].dma_addr;
      e.st = tbl[i].st; e.rd = tbl[i].rd; e.rc = tbl[i].rc; e.cv = tbl[i].cv;
      e.ermax = tbl[i].ermax; e.ormin = tbl[i].ormin;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("state", i, 32'(bus.state_o), 32'(e.st));
      chk("run_done", i, 32'(bus.run_done), 32'(e.rd));
      chk("run_count", i, 32'(bus.run_count), 32'(e.rc));
      chk("cfg_valid", i, 32'(bus.cfg_valid), 32'(e.cv));
      chk("ER_max", i, 32'(bus.ER_max), 32'(e.ermax));
      chk("OR_min", i, 32'(bus.OR_min), 32'(e.ormin));
    end
    chk("ER_min_final", -2, 32'(bus.ER_min), 32'hE000);
    chk("OR_max_final", -2, 32'(bus.OR_max), 32'h0210);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
